// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the masked single-port SRAM model.
package sram_pkg;

    // Controller states: clearing the array, or serving accesses.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sram_state_e;

    // Ceiling log2, used to check that the address bus covers the depth.
    function automatic int clog2(input int unsigned value);
        int          r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line: STAGES register stages carrying data and valid.
// Only the valid bits are reset; data follows valid and needs no reset.
module sram_rd_pipe #(
    parameter int DATA_WIDTH = 174,
    parameter int STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] dat_o
);

    logic [STAGES-1:0]     vld_pipe;
    logic [DATA_WIDTH-1:0] dat_pipe [STAGES];

    // Valid shift register, cleared asynchronously so no stale pulse survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= vld_i;
            for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Data shift register, unreset.
    always_ff @(posedge clk) begin
        dat_pipe[0] <= dat_i;
        for (int i = 1; i < STAGES; i++) dat_pipe[i] <= dat_pipe[i-1];
    end

    assign vld_o = vld_pipe[STAGES-1];
    assign dat_o = dat_pipe[STAGES-1];

endmodule

// File: rtl/sram_sp_mask_init.sv
// Single-port byte-group-masked SRAM with configurable read latency and a
// hardware clear engine that zeroes the array after reset or on request.
module sram_sp_mask_init
    import sram_pkg::*;
#(
    parameter  int DATA_WIDTH    = 174,
    parameter  int MASK_GRAN     = 29,
    parameter  int DEPTH         = 8192,
    parameter  int ADDR_WIDTH    = 13,
    parameter  int READ_LATENCY  = 1,
    parameter  int INIT_ON_RESET = 1,
    localparam int MASK_WIDTH    = DATA_WIDTH / MASK_GRAN
) (
    input  logic                  RW0_clk,
    input  logic                  RW0_rst_n,
    input  logic [ADDR_WIDTH-1:0] RW0_addr,
    input  logic                  RW0_en,
    input  logic                  RW0_wmode,
    input  logic [MASK_WIDTH-1:0] RW0_wmask,
    input  logic [DATA_WIDTH-1:0] RW0_wdata,
    output logic [DATA_WIDTH-1:0] RW0_rdata,
    output logic                  RW0_rvalid,
    input  logic                  init_req,
    output logic                  init_done
);

    // Configuration sanity checks, caught at elaboration.
    if (DATA_WIDTH % MASK_GRAN != 0) begin : g_bad_gran
        $error("DATA_WIDTH must be a multiple of MASK_GRAN");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
        $error("READ_LATENCY must be in 1..4");
    end
    if (clog2(DEPTH) > ADDR_WIDTH) begin : g_bad_addr
        $error("ADDR_WIDTH too narrow for DEPTH");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam sram_state_e           RST_STATE = (INIT_ON_RESET != 0) ? INIT : READY;

    sram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    logic                  in_range, rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] rd_raw;
    logic                  pipe_vld;
    logic [DATA_WIDTH-1:0] pipe_dat;

    assign init_done = (state_q == READY);
    assign in_range  = ({1'b0, RW0_addr} < DEPTH_W);
    assign rd_acc    = RW0_en && init_done && !RW0_wmode;
    assign wr_acc    = RW0_en && init_done &&  RW0_wmode && in_range;
    // Out-of-range reads still return a (zero) word so the requester sees rvalid.
    assign rd_raw    = in_range ? mem_q[RW0_addr] : '0;

    // Next-state logic: the clear walks 0..DEPTH-1 one word per cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (init_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    // FSM state and clear counter.
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array: clear writes take priority; user writes merge only enabled lanes.
    always_ff @(posedge RW0_clk) begin
        if (state_q == INIT) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (RW0_wmask[i]) begin
                    mem_q[RW0_addr][i*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Extra delay stages in front of the output register for latencies above one.
    if (READ_LATENCY > 1) begin : g_pipe
        sram_rd_pipe #(
            .DATA_WIDTH (DATA_WIDTH),
            .STAGES     (READ_LATENCY - 1)
        ) u_rd_pipe (
            .clk   (RW0_clk),
            .rst_n (RW0_rst_n),
            .vld_i (rd_acc),
            .dat_i (rd_raw),
            .vld_o (pipe_vld),
            .dat_o (pipe_dat)
        );
    end else begin : g_nopipe
        assign pipe_vld = rd_acc;
        assign pipe_dat = rd_raw;
    end

    // Output register: rdata only moves when a valid word leaves the pipe.
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= pipe_vld;
            if (pipe_vld) rdata_q <= pipe_dat;
        end
    end

    assign RW0_rdata  = rdata_q;
    assign RW0_rvalid = rvalid_q;

endmodule
